// File: rtl/divisor_pkg.sv
// Shared definitions for the divisor scheduler slice.
// Contents:
//   sched_state_t : scheduler FSM states (IDLE, START, BLANK, WAIT, RESP)
//   TAMANYO_DEF   : default operand/result width, same as the divider's tamanyo
//   NREQ_DEF      : default number of requesters
package divisor_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        BLANK = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } sched_state_t;

    localparam int TAMANYO_DEF = 32;
    localparam int NREQ_DEF    = 4;

endpackage

// File: rtl/divisor_scheduler_if.sv
// Client-side bundle of the divisor scheduler.
// Handshake: a requester raises req[i] with its operands on num_in/den_in and
// holds them until gnt[i] pulses (operands captured on that clock edge); later
// rsp_valid[i] pulses for one cycle while coc_out/res_out (and div_zero) carry
// its result. Dropping req after gnt does not cancel the operation.
// Signals:
//   req       NREQ          request levels
//   num_in    NREQ*tamanyo  numerators, requester i at [i*tamanyo +: tamanyo]
//   den_in    NREQ*tamanyo  denominators, same packing
//   gnt       NREQ          one-hot capture pulse
//   rsp_valid NREQ          one-hot result-valid pulse
//   coc_out   tamanyo       quotient, held until next response
//   res_out   tamanyo       remainder, held until next response
//   div_zero  1             zero-divisor flag, pulses with rsp_valid
// Modports: master = client side, slave = scheduler side.
interface divisor_scheduler_if #(
    parameter int NREQ    = 4,
    parameter int tamanyo = 32
);
    logic [NREQ-1:0]         req;
    logic [NREQ*tamanyo-1:0] num_in;
    logic [NREQ*tamanyo-1:0] den_in;
    logic [NREQ-1:0]         gnt;
    logic [NREQ-1:0]         rsp_valid;
    logic [tamanyo-1:0]      coc_out;
    logic [tamanyo-1:0]      res_out;
    logic                    div_zero;

    modport master (
        output req, num_in, den_in,
        input  gnt, rsp_valid, coc_out, res_out, div_zero
    );

    modport slave (
        input  req, num_in, den_in,
        output gnt, rsp_valid, coc_out, res_out, div_zero
    );
endinterface

// File: rtl/divisor_scheduler_rr_picker.sv
// Combinational round-robin picker.
// Searches req starting at index ptr and wrapping upward; the first set bit wins.
// Ports:
//   req   in  NREQ          request levels
//   ptr   in  clog2(NREQ)   highest-priority index this round
//   grant out NREQ          one-hot winner (all zero when no request)
//   idx   out clog2(NREQ)   winner index (0 when no request)
//   found out 1             any request present
module rr_picker #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic                    found
);
    localparam int IW = $clog2(NREQ);

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[IW'((int'(ptr) + k) % NREQ)]) begin
                found = 1'b1;
                idx   = IW'((int'(ptr) + k) % NREQ);
            end
        end
        if (found) grant[idx] = 1'b1;
    end
endmodule

// File: rtl/divisor_scheduler.sv
// Shares one Divisor_Algoritmico among NREQ requesters, round-robin.
// The granted requester's operands are latched and driven to the divider, Start
// is pulsed, and the result is returned on the shared bus with a one-hot valid.
// Optional feature: define DIV_ZERO_CHECK_EN to answer den==0 locally
// (coc='1, res=num, div_zero=1) without starting the divider.
// Ports:
//   CLK, RSTa   clock (rising edge) and asynchronous active-low reset
//   cli         client bundle (divisor_scheduler_if.slave)
//   busy        1 in every state except IDLE
//   div_start   divider Start, 1-cycle pulse
//   div_num/den divider operands, registered, stable START..RESP
//   div_coc/res divider results
//   div_done    divider Done (level or pulse)
//   state_dbg   current FSM state
module divisor_scheduler
    import divisor_pkg::*;
#(
    parameter int tamanyo = TAMANYO_DEF,
    parameter int NREQ    = NREQ_DEF
) (
    input  logic               CLK,
    input  logic               RSTa,
    divisor_scheduler_if.slave cli,
    output logic               busy,
    output logic               div_start,
    output logic [tamanyo-1:0] div_num,
    output logic [tamanyo-1:0] div_den,
    input  logic [tamanyo-1:0] div_coc,
    input  logic [tamanyo-1:0] div_res,
    input  logic               div_done,
    output sched_state_t       state_dbg
);
    localparam int IW = $clog2(NREQ);

    sched_state_t       state;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      owner;
    logic [tamanyo-1:0] coc_q;
    logic [tamanyo-1:0] res_q;
    logic [NREQ-1:0]    pick_gnt;
    logic [IW-1:0]      pick_idx;
    logic               pick_found;
    logic [tamanyo-1:0] sel_num;
    logic [tamanyo-1:0] sel_den;
    logic [NREQ-1:0]    rsp_vec;

    rr_picker #(.NREQ(NREQ)) u_picker (
        .req   (cli.req),
        .ptr   (ptr),
        .grant (pick_gnt),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign sel_num = cli.num_in[int'(pick_idx)*tamanyo +: tamanyo];
    assign sel_den = cli.den_in[int'(pick_idx)*tamanyo +: tamanyo];

`ifdef DIV_ZERO_CHECK_EN
    // Set at capture when the divisor is zero; qualifies div_zero in RESP.
    logic zero_q;

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            zero_q <= 1'b0;
        end else if (state == IDLE && pick_found) begin
            zero_q <= (sel_den == '0);
        end
    end

    assign cli.div_zero = (state == RESP) && zero_q;
`else
    assign cli.div_zero = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            state   <= IDLE;
            ptr     <= '0;
            owner   <= '0;
            div_num <= '0;
            div_den <= '0;
            coc_q   <= '0;
            res_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        owner   <= pick_idx;
                        div_num <= sel_num;
                        div_den <= sel_den;
`ifdef DIV_ZERO_CHECK_EN
                        if (sel_den == '0) begin
                            coc_q <= '1;
                            res_q <= sel_num;
                            state <= RESP;
                        end else begin
                            state <= START;
                        end
`else
                        state <= START;
`endif
                    end
                end
                START: state <= BLANK;
                // Done may still be asserted from the previous division here.
                BLANK: state <= WAIT;
                WAIT: begin
                    if (div_done) begin
                        coc_q <= div_coc;
                        res_q <= div_res;
                        state <= RESP;
                    end
                end
                RESP: begin
                    // The requester just served becomes lowest priority.
                    ptr   <= (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        rsp_vec = '0;
        if (state == RESP) rsp_vec[owner] = 1'b1;
    end

    assign cli.gnt       = (state == IDLE) ? pick_gnt : '0;
    assign cli.rsp_valid = rsp_vec;
    assign cli.coc_out   = coc_q;
    assign cli.res_out   = res_q;
    assign div_start     = (state == START);
    assign busy          = (state != IDLE);
    assign state_dbg     = state;
endmodule

// File: tb/tb_divisor_scheduler.sv
module tb_divisor_scheduler;
    import divisor_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = 32;

    // ---------------- clock / reset ----------------
    logic CLK  = 1'b0;
    logic RSTa = 1'b0;
    int   cyc  = 0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    divisor_scheduler_if #(.NREQ(NREQ), .tamanyo(W)) cli ();

    logic         busy, div_start, div_done;
    logic [W-1:0] div_num, div_den, div_coc, div_res;
    sched_state_t state_dbg;

    divisor_scheduler #(.tamanyo(W), .NREQ(NREQ)) dut (
        .CLK       (CLK),
        .RSTa      (RSTa),
        .cli       (cli),
        .busy      (busy),
        .div_start (div_start),
        .div_num   (div_num),
        .div_den   (div_den),
        .div_coc   (div_coc),
        .div_res   (div_res),
        .div_done  (div_done),
        .state_dbg (state_dbg)
    );

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // First requester at or above p (wrapping) wins.
    function automatic logic [NREQ-1:0] rr_winner(input logic [NREQ-1:0] r, input int p);
        logic [NREQ-1:0] w = '0;
        for (int k = 0; k < NREQ; k++)
            if (w == '0 && r[(p + k) % NREQ]) w[(p + k) % NREQ] = 1'b1;
        return w;
    endfunction

    // ---------------- divider model ----------------
    // Done rises D cycles after the Start cycle ends; in level mode it stays high
    // until one cycle after the next Start, so a stale Done overlaps BLANK.
    int           d_force   = 0;   // 0 = random latency
    int           dv_mode   = 0;   // 0 random, 1 level, 2 pulse
    int           dv_d      = 0;
    int           dv_cnt    = 0;
    int           dv_last_d = 0;
    int           dv_nstart = 0;
    logic         dv_start_d, dv_pulse;
    logic [W-1:0] dv_num, dv_den;

    always @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            div_done   <= 1'b0;
            div_coc    <= '0;
            div_res    <= '0;
            dv_cnt     <= 0;
            dv_start_d <= 1'b0;
            dv_pulse   <= 1'b0;
        end else begin
            dv_start_d <= div_start;
            if (dv_start_d || (dv_pulse && div_done)) div_done <= 1'b0;
            if (div_start) begin
                dv_d = (d_force != 0) ? d_force : int'($urandom_range(2, 6));
                dv_last_d <= dv_d;
                dv_cnt    <= dv_d;
                dv_nstart <= dv_nstart + 1;
                dv_num    <= div_num;
                dv_den    <= div_den;
                dv_pulse  <= (dv_mode == 0) ? 1'($urandom_range(0, 1)) : (dv_mode == 2);
            end else if (dv_cnt > 0) begin
                dv_cnt <= dv_cnt - 1;
                if (dv_cnt == 1) begin
                    div_done <= 1'b1;
                    div_coc  <= (dv_den != 0) ? dv_num / dv_den : '1;
                    div_res  <= (dv_den != 0) ? dv_num % dv_den : dv_num;
                end
            end
        end
    end

    // ---------------- scoreboard / reference model ----------------
    logic [W-1:0]    exp_q[$];      // expected {coc, res} pairs, pushed in order
    logic [W-1:0]    exp_r_q[$];
    int              m_ptr   = 0;
    bit              in_op   = 0;
    bit              was_in  = 0;
    bit              m_zero  = 0;
    int              m_owner = 0;
    int              m_gcyc  = 0;
    int              m_rcyc  = 0;
    int              n_rsp   = 0;
    logic [W-1:0]    m_num, m_den, e_coc, e_res;
    logic [NREQ-1:0] m_win, m_rv;
    bit              granted[NREQ];

    always @(negedge CLK) begin
        if (!RSTa) begin
            exp_q.delete();
            exp_r_q.delete();
            in_op = 0;
            m_ptr = 0;
        end else begin
            was_in = in_op;
            m_win  = rr_winner(cli.req, m_ptr);
            check("busy", 32'(busy), 32'(in_op));
            check("gnt", 32'(cli.gnt), in_op ? 32'd0 : 32'(m_win));
            check("div_start", 32'(div_start), 32'(in_op && !m_zero && cyc == m_gcyc + 1));
            if (in_op) begin
                check("div_num", div_num, m_num);
                check("div_den", div_den, m_den);
            end
            m_rcyc = m_zero ? m_gcyc + 1 : m_gcyc + 3 + dv_last_d;
            m_rv   = (in_op && cyc == m_rcyc) ? onehot(m_owner) : '0;
            check("rsp_valid", 32'(cli.rsp_valid), 32'(m_rv));
            check("div_zero", 32'(cli.div_zero), 32'(m_rv != '0 && m_zero));
            if (cli.rsp_valid != '0 && exp_q.size() > 0) begin
                e_coc = exp_q.pop_front();
                e_res = exp_r_q.pop_front();
                check("coc_out", cli.coc_out, e_coc);
                check("res_out", cli.res_out, e_res);
                in_op = 0;
                m_ptr = (m_owner + 1) % NREQ;
                n_rsp++;
            end
            if (!was_in && m_win != '0) begin
                for (int i = 0; i < NREQ; i++) if (m_win[i]) m_owner = i;
                m_num  = cli.num_in[m_owner*W +: W];
                m_den  = cli.den_in[m_owner*W +: W];
                m_gcyc = cyc;
`ifdef DIV_ZERO_CHECK_EN
                m_zero = (m_den == '0);
`else
                m_zero = 0;
`endif
                exp_q.push_back((m_den != 0) ? m_num / m_den : '1);
                exp_r_q.push_back((m_den != 0) ? m_num % m_den : m_num);
                granted[m_owner] = 1;
                in_op = 1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_op(input int i, input logic [W-1:0] n, input logic [W-1:0] d);
        cli.num_in[i*W +: W] = n;
        cli.den_in[i*W +: W] = d;
    endtask

    task automatic wait_gnt(output int idx, output int gc);
        idx = -1;
        gc  = 0;
        for (int t = 0; t < 100 && idx < 0; t++) begin
            @(negedge CLK);
            if (cli.gnt != '0) begin
                for (int i = 0; i < NREQ; i++) if (cli.gnt[i]) idx = i;
                gc = cyc;
            end
        end
        if (idx < 0) check("gnt_timeout", 32'd1, 32'd0);
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_rsp(output logic [NREQ-1:0] vec, output logic [W-1:0] coc,
                            output logic [W-1:0] res, output logic zero, output int rc);
        vec = '0; coc = '0; res = '0; zero = 1'b0; rc = 0;
        for (int t = 0; t < 100 && vec == '0; t++) begin
            @(negedge CLK);
            if (cli.rsp_valid != '0) begin
                vec  = cli.rsp_valid;
                coc  = cli.coc_out;
                res  = cli.res_out;
                zero = cli.div_zero;
                rc   = cyc;
            end
        end
        if (vec == '0) check("rsp_timeout", 32'd1, 32'd0);
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge CLK);
            if (!busy) done = 1;
        end
        if (!done) check("idle_timeout", 32'd1, 32'd0);
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #2 RSTa = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK) RSTa = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [W-1:0] rnd_den();
        logic [W-1:0] d = $urandom >> $urandom_range(0, 31);
`ifdef DIV_ZERO_CHECK_EN
        if ($urandom_range(0, 7) == 0) return '0;
`endif
        return (d == '0) ? 32'd1 : d;
    endfunction

    // ---------------- stimulus ----------------
    int              g, gc, rc, g0, target, ns0;
    logic [NREQ-1:0] rv;
    logic [W-1:0]    rcoc, rres;
    logic            rz;
    int              order2[5] = '{0, 1, 2, 3, 0};

    initial begin
        cli.req    = '0;
        cli.num_in = '0;
        cli.den_in = '0;

        // Reset values
        repeat (3) @(posedge CLK);
        #1;
        check("rst_gnt", 32'(cli.gnt), 32'd0);
        check("rst_rsp_valid", 32'(cli.rsp_valid), 32'd0);
        check("rst_coc", cli.coc_out, 32'd0);
        check("rst_res", cli.res_out, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_div_start", 32'(div_start), 32'd0);
        check("rst_div_num", div_num, 32'd0);
        check("rst_div_den", div_den, 32'd0);
        check("rst_div_zero", 32'(cli.div_zero), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        @(negedge CLK) RSTa = 1'b1;
        @(posedge CLK);
        #1;

        // Single request 100/7, dropped right after its grant
        d_force = 4;
        set_op(0, 32'd100, 32'd7);
        cli.req = 4'b0001;
        wait_gnt(g, gc);
        check("t1_gnt_idx", 32'(g), 32'd0);
        cli.req[0] = 1'b0;
        wait_rsp(rv, rcoc, rres, rz, rc);
        check("t1_rsp_vec", 32'(rv), 32'b0001);
        check("t1_coc", rcoc, 32'd14);
        check("t1_res", rres, 32'd2);
        check("t1_latency", 32'(rc - gc), 32'd7);
        d_force = 0;

        // All four requesting: strict rotation from index 0 after reset
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, 32'd1000 + 32'(i) * 32'd337, 32'd3 + 32'(i));
        cli.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(g, gc);
            check("t2_order", 32'(g), 32'(order2[k]));
        end
        cli.req = '0;
        wait_idle();

        // After a grant to 2, requesters 0 and 2 pending: 0 wins (wrap), then 2
        set_op(2, 32'd999, 32'd10);
        set_op(0, 32'd55, 32'd6);
        cli.req = 4'b0100;
        wait_gnt(g, gc);
        check("t3_first", 32'(g), 32'd2);
        cli.req = 4'b0101;
        wait_gnt(g, gc);
        check("t3_wrap", 32'(g), 32'd0);
        cli.req[0] = 1'b0;
        wait_gnt(g, gc);
        check("t3_then", 32'(g), 32'd2);
        cli.req = '0;
        wait_idle();

        // Reset while waiting for Done: silent abort, pointer back to 0
        d_force = 6;
        set_op(0, 32'd12345, 32'd11);
        cli.req = 4'b0001;
        wait_gnt(g, gc);
        cli.req = '0;
        repeat (3) @(posedge CLK);
        #2 RSTa = 1'b0;
        #1;
        check("t4_state_before", 32'(state_dbg), 32'(IDLE));
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_rsp_valid", 32'(cli.rsp_valid), 32'd0);
        check("t4_div_num", div_num, 32'd0);
        check("t4_div_den", div_den, 32'd0);
        check("t4_coc", cli.coc_out, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check("t4_no_rsp", 32'(cli.rsp_valid), 32'd0);
        end
        RSTa    = 1'b1;
        d_force = 0;
        @(posedge CLK);
        #1;
        set_op(1, 32'd81, 32'd9);
        cli.req = 4'b0010;
        wait_gnt(g, gc);
        check("t4_after_rst", 32'(g), 32'd1);
        cli.req = '0;
        wait_rsp(rv, rcoc, rres, rz, rc);
        check("t4_coc_after", rcoc, 32'd9);

        // Level Done held from the previous op must not be taken as the new result
        dv_mode = 1;
        d_force = 5;
        set_op(0, 32'd1000, 32'd3);
        set_op(1, 32'd77, 32'd5);
        cli.req = 4'b0011;
        wait_gnt(g, gc);
        check("t6_first", 32'(g), 32'd0);
        cli.req[0] = 1'b0;
        wait_rsp(rv, rcoc, rres, rz, rc);
        check("t6_coc_a", rcoc, 32'd333);
        check("t6_res_a", rres, 32'd1);
        wait_gnt(g, gc);
        check("t6_second", 32'(g), 32'd1);
        cli.req = '0;
        wait_rsp(rv, rcoc, rres, rz, rc);
        check("t6_coc_b", rcoc, 32'd15);
        check("t6_res_b", rres, 32'd2);
        dv_mode = 0;
        d_force = 0;

`ifdef DIV_ZERO_CHECK_EN
        // Zero divisor answered locally, divider never started
        ns0 = dv_nstart;
        set_op(2, 32'd5, 32'd0);
        cli.req = 4'b0100;
        wait_gnt(g, gc);
        cli.req = '0;
        wait_rsp(rv, rcoc, rres, rz, rc);
        check("t5_latency", 32'(rc - gc), 32'd1);
        check("t5_coc", rcoc, 32'hFFFF_FFFF);
        check("t5_res", rres, 32'd5);
        check("t5_div_zero", 32'(rz), 32'd1);
        check("t5_no_start", 32'(dv_nstart - ns0), 32'd0);
`endif

        // Randomized traffic against the scoreboard
        target = n_rsp + 60;
        for (int t = 0; t < 4000 && n_rsp < target; t++) begin
            @(posedge CLK);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (!cli.req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        set_op(i, $urandom >> $urandom_range(0, 16), rnd_den());
                        granted[i] = 0;
                        cli.req[i] = 1'b1;
                    end
                end else if (granted[i] && $urandom_range(0, 2) == 0) begin
                    cli.req[i] = 1'b0;
                end
            end
        end
        check("rand_progress", 32'(n_rsp >= target), 32'd1);
        cli.req = '0;
        wait_idle();
        repeat (2) @(posedge CLK);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end
endmodule
